lockstep_fault_monitor: RTL and testbench

Downstream checker for the dual-ALU lockstep pair in the user project. Consumes both ALU result/carry outputs and their select codes each valid cycle, computes the XOR mismatch syndrome in a registered compare stage, and runs a debounce state machine that declares a latched fault after `CONFIRM_N` consecutive mismatching samples. It captures the first syndrome of the confirming run, keeps saturating sample and mismatch counters, and raises a one-cycle interrupt pulse intended for `user_irq`.

---
 rtl/lockstep_fault_monitor.sv | 138 +++++++++++++
 tb/tb_lockstep_fault_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_fault_monitor.sv
// Lockstep checker for the dual-ALU pair. It registers the XOR syndrome of the two ALUs,
// debounces consecutive mismatches into a latched fault and pulses an interrupt on entry.
module lockstep_fault_monitor #(
  parameter int unsigned CONFIRM_N = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             sample_valid,
  input  logic [7:0]       alu_out1,
  input  logic [7:0]       alu_out2,
  input  logic             carry1,
  input  logic             carry2,
  input  logic [1:0]       alu_sel1,
  input  logic [1:0]       alu_sel2,
  input  logic             fault_clr,
  output logic             fault_o,
  output logic             suspect_o,
  output logic             irq_o,
  output logic [7:0]       syn_x,
  output logic             syn_y,
  output logic             syn_sel_err,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  localparam logic [3:0]       CONFIRM = 4'(CONFIRM_N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state;
  logic [3:0] consec;
  logic       v_q;
  logic [7:0] x_q;
  logic       y_q;
  logic       s_q;
  logic       mm_q;

  logic [7:0] x_d;
  logic       y_d;
  logic       s_d;

  assign x_d = alu_out1 ^ alu_out2;
  assign y_d = carry1 ^ carry2;
  assign s_d = (alu_sel1 != alu_sel2);

  assign fault_o   = (state == ST_FAULT);
  assign suspect_o = (state == ST_SUSPECT);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_OK;
      consec       <= 4'd0;
      v_q          <= 1'b0;
      x_q          <= 8'd0;
      y_q          <= 1'b0;
      s_q          <= 1'b0;
      mm_q         <= 1'b0;
      irq_o        <= 1'b0;
      syn_x        <= 8'd0;
      syn_y        <= 1'b0;
      syn_sel_err  <= 1'b0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
    end else begin
      // Compare stage: mm_q is formed from the raw inputs so it lines up with v_q/x_q.
      v_q  <= sample_valid;
      x_q  <= x_d;
      y_q  <= y_d;
      s_q  <= s_d;
      mm_q <= sample_valid & ((|x_d) | y_d | s_d);

      if (v_q && (sample_cnt != CNT_MAX))
        sample_cnt <= sample_cnt + CNT_ONE;
      if (mm_q && (mismatch_cnt != CNT_MAX))
        mismatch_cnt <= mismatch_cnt + CNT_ONE;

      irq_o <= 1'b0;

      // Clear wins over any transition the stage-2 sample would cause; counters still count it.
      if (fault_clr) begin
        state       <= ST_OK;
        consec      <= 4'd0;
        syn_x       <= 8'd0;
        syn_y       <= 1'b0;
        syn_sel_err <= 1'b0;
      end else begin
        case (state)
          ST_OK: begin
            if (mm_q) begin
              syn_x       <= x_q;
              syn_y       <= y_q;
              syn_sel_err <= s_q;
              consec      <= 4'd1;
              if (CONFIRM == 4'd1) begin
                state <= ST_FAULT;
                irq_o <= 1'b1;
              end else begin
                state <= ST_SUSPECT;
              end
            end else if (v_q) begin
              consec <= 4'd0;
            end
          end
          ST_SUSPECT: begin
            if (mm_q) begin
              consec <= consec + 4'd1;
              if ((consec + 4'd1) == CONFIRM) begin
                state <= ST_FAULT;
                irq_o <= 1'b1;
              end
            end else if (v_q) begin
              state       <= ST_OK;
              consec      <= 4'd0;
              syn_x       <= 8'd0;
              syn_y       <= 1'b0;
              syn_sel_err <= 1'b0;
            end
          end
          ST_FAULT: begin
            state <= ST_FAULT;
          end
          default: begin
            state  <= ST_OK;
            consec <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lockstep_fault_monitor.sv
// Bench for lockstep_fault_monitor: a vector table drives the default instance through a
// scoreboard queue, and hand sequences cover saturation, CONFIRM_N=1/3 and mid-run reset.
module tb_lockstep_fault_monitor;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [7:0] alu_out1, alu_out2;
  logic       carry1, carry2;
  logic [1:0] alu_sel1, alu_sel2;
  logic       fault_clr;

  logic        a_fault, a_suspect, a_irq, a_sy, a_ss;
  logic [7:0]  a_sx;
  logic [15:0] a_sc, a_mc;

  logic        b_fault, b_suspect, b_irq, b_sy, b_ss;
  logic [7:0]  b_sx;
  logic [3:0]  b_sc, b_mc;

  logic        c_fault, c_suspect, c_irq, c_sy, c_ss;
  logic [7:0]  c_sx;
  logic [15:0] c_sc, c_mc;

  lockstep_fault_monitor dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .sample_valid(sample_valid),
    .alu_out1(alu_out1), .alu_out2(alu_out2), .carry1(carry1), .carry2(carry2),
    .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .fault_clr(fault_clr),
    .fault_o(a_fault), .suspect_o(a_suspect), .irq_o(a_irq),
    .syn_x(a_sx), .syn_y(a_sy), .syn_sel_err(a_ss),
    .sample_cnt(a_sc), .mismatch_cnt(a_mc)
  );

  lockstep_fault_monitor #(.CONFIRM_N(3), .CNT_W(4)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .sample_valid(sample_valid),
    .alu_out1(alu_out1), .alu_out2(alu_out2), .carry1(carry1), .carry2(carry2),
    .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .fault_clr(fault_clr),
    .fault_o(b_fault), .suspect_o(b_suspect), .irq_o(b_irq),
    .syn_x(b_sx), .syn_y(b_sy), .syn_sel_err(b_ss),
    .sample_cnt(b_sc), .mismatch_cnt(b_mc)
  );

  lockstep_fault_monitor #(.CONFIRM_N(1)) dut_c (
    .wb_clk_i(clk), .wb_rst_i(rst), .sample_valid(sample_valid),
    .alu_out1(alu_out1), .alu_out2(alu_out2), .carry1(carry1), .carry2(carry2),
    .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .fault_clr(fault_clr),
    .fault_o(c_fault), .suspect_o(c_suspect), .irq_o(c_irq),
    .syn_x(c_sx), .syn_y(c_sy), .syn_sel_err(c_ss),
    .sample_cnt(c_sc), .mismatch_cnt(c_mc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  a, b;
    logic        c1, c2;
    logic [1:0]  s1, s2;
    logic        clr;
    logic [44:0] exp;
  } vec_t;

  vec_t        vtab[$];
  logic [44:0] exp_q[$];
  int          id_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        pend_clr = 1'b0;

  // Expected word order: fault, suspect, irq, syn_x, syn_y, syn_sel_err, sample_cnt, mismatch_cnt
  function automatic logic [44:0] ex(input logic f, input logic su, input logic irq,
                                     input logic [7:0] sx, input logic sy, input logic ss,
                                     input int sc, input int mc);
    return {f, su, irq, sx, sy, ss, 16'(sc), 16'(mc)};
  endfunction

  function automatic vec_t vec(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic c1, input logic c2, input logic [1:0] s1,
                               input logic [1:0] s2, input logic clr, input logic [44:0] e);
    vec_t r;
    r.v = v; r.a = a; r.b = b; r.c1 = c1; r.c2 = c2;
    r.s1 = s1; r.s2 = s2; r.clr = clr; r.exp = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_idle();
    sample_valid = 1'b0;
    alu_out1 = 8'h00; alu_out2 = 8'h00;
    carry1 = 1'b0; carry2 = 1'b0;
    alu_sel1 = 2'b00; alu_sel2 = 2'b00;
  endtask

  task automatic drive_mm(input logic [7:0] b);
    sample_valid = 1'b1;
    alu_out1 = 8'h3C; alu_out2 = b;
    carry1 = 1'b0; carry2 = 1'b0;
    alu_sel1 = 2'b00; alu_sel2 = 2'b00;
  endtask

  // Scoreboard: pop the oldest expectation once the DUT has produced its output.
  task automatic check_out();
    logic [44:0] e;
    int          id;
    e  = exp_q.pop_front();
    id = id_q.pop_front();
    chk($sformatf("vec%0d", id),
        64'({a_fault, a_suspect, a_irq, a_sx, a_sy, a_ss, a_sc, a_mc}), 64'(e));
  endtask

  // A record's clr is asserted on the cycle that record's sample sits in stage 2.
  task automatic step(input vec_t vv, input int id);
    @(negedge clk);
    if (exp_q.size() >= 2) check_out();
    sample_valid = vv.v;
    alu_out1 = vv.a; alu_out2 = vv.b;
    carry1 = vv.c1; carry2 = vv.c2;
    alu_sel1 = vv.s1; alu_sel2 = vv.s2;
    fault_clr = pend_clr;
    pend_clr = vv.clr;
    exp_q.push_back(vv.exp);
    id_q.push_back(id);
  endtask

  task automatic drain();
    repeat (2) begin
      @(negedge clk);
      if (exp_q.size() > 0) check_out();
      drive_idle();
      fault_clr = pend_clr;
      pend_clr = 1'b0;
    end
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    fault_clr = 1'b0;
    pend_clr = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk({tag, "_a"}, 64'({a_fault, a_suspect, a_irq, a_sx, a_sy, a_ss, a_sc, a_mc}), 64'(0));
    chk({tag, "_b"}, 64'({b_fault, b_suspect, b_irq, b_sx, b_sy, b_ss, b_sc, b_mc}), 64'(0));
    chk({tag, "_c"}, 64'({c_fault, c_suspect, c_irq, c_sx, c_sy, c_ss, c_sc, c_mc}), 64'(0));
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fault_clr = 1'b0;
    drive_idle();

    // Equal results: counts only
    for (int i = 1; i <= 10; i++)
      vtab.push_back(vec(1, 8'h3C, 8'h3C, 0, 0, 2'b00, 2'b00, 0, ex(0, 0, 0, 8'h00, 0, 0, i, 0)));
    // Single mismatch then match: one SUSPECT cycle, back to OK
    vtab.push_back(vec(1, 8'h3C, 8'h34, 0, 0, 2'b00, 2'b00, 0, ex(0, 1, 0, 8'h08, 0, 0, 11, 1)));
    vtab.push_back(vec(1, 8'h3C, 8'h3C, 0, 0, 2'b00, 2'b00, 0, ex(0, 0, 0, 8'h00, 0, 0, 12, 1)));
    // Mismatch, two idle cycles, mismatch: FAULT keeps the first syndrome
    vtab.push_back(vec(1, 8'h3C, 8'h34, 0, 0, 2'b00, 2'b00, 0, ex(0, 1, 0, 8'h08, 0, 0, 13, 2)));
    vtab.push_back(vec(0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0, ex(0, 1, 0, 8'h08, 0, 0, 13, 2)));
    vtab.push_back(vec(0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0, ex(0, 1, 0, 8'h08, 0, 0, 13, 2)));
    vtab.push_back(vec(1, 8'h3C, 8'hC3, 0, 0, 2'b00, 2'b00, 0, ex(1, 0, 1, 8'h08, 0, 0, 14, 3)));
    vtab.push_back(vec(1, 8'h3C, 8'h3C, 0, 0, 2'b00, 2'b00, 0, ex(1, 0, 0, 8'h08, 0, 0, 15, 3)));
    vtab.push_back(vec(1, 8'h3C, 8'h00, 0, 0, 2'b00, 2'b00, 0, ex(1, 0, 0, 8'h08, 0, 0, 16, 4)));
    vtab.push_back(vec(0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 1, ex(0, 0, 0, 8'h00, 0, 0, 16, 4)));
    // Carry-only mismatch to FAULT, clear, then select-only mismatch to FAULT
    vtab.push_back(vec(1, 8'h55, 8'h55, 1, 0, 2'b00, 2'b00, 0, ex(0, 1, 0, 8'h00, 1, 0, 17, 5)));
    vtab.push_back(vec(1, 8'h55, 8'h55, 1, 0, 2'b00, 2'b00, 0, ex(1, 0, 1, 8'h00, 1, 0, 18, 6)));
    vtab.push_back(vec(0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 1, ex(0, 0, 0, 8'h00, 0, 0, 18, 6)));
    vtab.push_back(vec(1, 8'h5A, 8'h5A, 0, 0, 2'b01, 2'b00, 0, ex(0, 1, 0, 8'h00, 0, 1, 19, 7)));
    vtab.push_back(vec(1, 8'h5A, 8'h5A, 0, 0, 2'b01, 2'b00, 0, ex(1, 0, 1, 8'h00, 0, 1, 20, 8)));
    vtab.push_back(vec(0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0, ex(1, 0, 0, 8'h00, 0, 1, 20, 8)));
    // Clear racing the confirming mismatch: stays OK, no irq, still counted
    vtab.push_back(vec(0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 1, ex(0, 0, 0, 8'h00, 0, 0, 20, 8)));
    vtab.push_back(vec(1, 8'h3C, 8'h34, 0, 0, 2'b00, 2'b00, 0, ex(0, 1, 0, 8'h08, 0, 0, 21, 9)));
    vtab.push_back(vec(1, 8'h3C, 8'hC3, 0, 0, 2'b00, 2'b00, 1, ex(0, 0, 0, 8'h00, 0, 0, 22, 10)));
    vtab.push_back(vec(1, 8'h3C, 8'h3C, 0, 0, 2'b00, 2'b00, 0, ex(0, 0, 0, 8'h00, 0, 0, 23, 10)));
    // Clear beats capture of a fresh mismatch in OK
    vtab.push_back(vec(1, 8'h3C, 8'h34, 0, 0, 2'b00, 2'b00, 1, ex(0, 0, 0, 8'h00, 0, 0, 24, 11)));
    vtab.push_back(vec(0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0, ex(0, 0, 0, 8'h00, 0, 0, 24, 11)));

    do_reset("reset0");
    for (int i = 0; i < vtab.size(); i++) step(vtab[i], i);
    drain();

    // 20 mismatches: CONFIRM_N=3/CNT_W=4 instance and CONFIRM_N=1 instance
    do_reset("reset1");
    @(negedge clk);
    drive_mm(8'h34);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      drive_mm(8'h34);
      if (k == 2) begin
        chk("b_suspect_1st", 64'({b_fault, b_suspect, b_irq, b_mc}), 64'({3'b010, 4'd1}));
        chk("c_fault_1st", 64'({c_fault, c_suspect, c_irq, c_sx}), 64'({3'b101, 8'h08}));
      end
      if (k == 3) begin
        chk("b_suspect_2nd", 64'({b_fault, b_suspect, b_irq, b_mc}), 64'({3'b010, 4'd2}));
        chk("c_irq_once", 64'({c_fault, c_irq}), 64'(2'b10));
      end
      if (k == 4)
        chk("b_fault_3rd", 64'({b_fault, b_suspect, b_irq, b_sx, b_mc}), 64'({3'b101, 8'h08, 4'd3}));
      if (k == 5)
        chk("b_irq_once", 64'({b_fault, b_irq}), 64'(2'b10));
    end
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    chk("b_saturate", 64'({b_fault, b_sx, b_sc, b_mc}), 64'({1'b1, 8'h08, 4'hF, 4'hF}));
    chk("c_counts", 64'({c_sc, c_mc}), 64'({16'd20, 16'd20}));

    // Clear leaves the counters alone
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("b_clear", 64'({b_fault, b_suspect, b_sx, b_sc, b_mc}), 64'({2'b00, 8'h00, 4'hF, 4'hF}));

    // Reset while in SUSPECT with a mismatch in flight
    drive_mm(8'h34);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    chk("b_suspect_again", 64'({b_fault, b_suspect, b_sx}), 64'({2'b01, 8'h08}));
    drive_mm(8'hFF);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    chk("b_reset_mid", 64'({b_fault, b_suspect, b_irq, b_sx, b_sy, b_ss, b_sc, b_mc}), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_inflight_dropped", 64'({b_fault, b_suspect, b_irq, b_sx, b_sy, b_ss, b_sc, b_mc}), 64'(0));
    chk("a_inflight_dropped", 64'({a_fault, a_suspect, a_irq, a_sx, a_sy, a_ss, a_sc, a_mc}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
